iob_ibus_prefetch: RTL and testbench

Sequential instruction prefetch buffer between the CPU wrapper's instruction bus and instruction memory. It answers fetches that hit the next expected word from a small FIFO in the same cycle. It speculatively fetches the following words, and restarts the stream on any non-sequential fetch (branch, jump, trap). It uses the native valid/ready memory protocol on both sides, with at most one memory transaction outstanding.

---
 rtl/iob_ibus_prefetch.sv | 182 ++++++++++++++++++
 tb/tb_iob_ibus_prefetch.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_ibus_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : iob_ibus_prefetch
// Description : Sequential instruction prefetch buffer between the CPU
//               instruction bus and instruction memory. Fetches that match
//               the next expected word are answered from a small FIFO in the
//               same cycle. The following words are fetched speculatively,
//               and the stream restarts on any non-sequential fetch.
//               Both sides use a valid/ready protocol. At most one memory
//               transaction is outstanding at any time.
// Ports       : clk             clock, all state on rising edge
//               resetn          asynchronous active-low reset
//               c_valid/c_addr  CPU fetch request (address bits [1:0] ignored)
//               c_rdata/c_ready fetched word and combinational completion
//               m_valid/m_addr  registered memory request (word aligned)
//               m_rdata/m_ready memory read data and completion
// Revision    : 1.0 - initial release
// ============================================================================
module iob_ibus_prefetch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              c_valid,
    input  logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_ready,
    output logic              m_valid,
    output logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W-1:0] C_WORD_STEP = ADDR_W'(DATA_W / 8);
    localparam logic [CNT_W-1:0]  C_DEPTH     = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0]  C_IDX_MASK  = IDX_W'(DEPTH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FETCH = 1'b1;

    // Registered state
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_head_addr;
    logic [ADDR_W-1:0] r_fetch_addr;
    logic [CNT_W-1:0]  r_count;
    logic              r_stream_valid;
    logic              r_discard;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_fifo [0:DEPTH-1];

    // Next-state and classification
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_head_nxt;
    logic [ADDR_W-1:0] w_fetch_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_stream_nxt;
    logic              w_discard_nxt;
    logic [ADDR_W-1:0] w_m_addr_nxt;
    logic              w_push;
    logic              w_issue;

    logic [ADDR_W-1:0] w_a;
    logic              w_busy;
    logic              w_seq;
    logic              w_hit;
    logic              w_fwd;
    logic              w_miss;
    logic              w_mem_done;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [IDX_W-1:0]  w_wr_idx;
    logic              w_unused_addr_lsb;

    assign w_unused_addr_lsb = ^c_addr[1:0];

    assign w_a        = {c_addr[ADDR_W-1:2], 2'b00};
    assign w_busy     = (r_state == S_FETCH);
    assign w_seq      = r_stream_valid && (w_a == r_head_addr);
    assign w_hit      = c_valid && w_seq && (r_count != '0);
    assign w_fwd      = c_valid && w_seq && (r_count == '0) && w_busy && !r_discard;
    assign w_miss     = c_valid && !w_seq;
    assign w_mem_done = w_busy && m_ready;

    // FIFO words live at consecutive addresses, so the slot of a word is
    // simply its word address modulo DEPTH; no separate pointers needed.
    assign w_rd_idx = r_head_addr[2 +: IDX_W] & C_IDX_MASK;
    assign w_wr_idx = r_fetch_addr[2 +: IDX_W] & C_IDX_MASK;

    assign c_ready = w_hit || (w_fwd && m_ready);
    assign c_rdata = w_hit ? r_fifo[w_rd_idx] : m_rdata;
    assign m_valid = w_busy;
    assign m_addr  = r_m_addr;

    always_comb begin
        w_state_nxt   = r_state;
        w_head_nxt    = r_head_addr;
        w_fetch_nxt   = r_fetch_addr;
        w_count_nxt   = r_count;
        w_stream_nxt  = r_stream_valid;
        w_discard_nxt = r_discard;
        w_m_addr_nxt  = r_m_addr;
        w_push        = 1'b0;

        if (w_miss) begin
            // Restart the stream at A. A completing fetch in this cycle is
            // simply dropped; a still-pending one must be discarded later.
            w_count_nxt   = '0;
            w_head_nxt    = w_a;
            w_fetch_nxt   = w_a;
            w_stream_nxt  = 1'b1;
            w_discard_nxt = w_busy && !m_ready;
        end else begin
            if (w_mem_done) begin
                if (r_discard) begin
                    w_discard_nxt = 1'b0;
                end else begin
                    // A forwarded word is consumed directly and never stored.
                    w_push      = !w_fwd;
                    w_fetch_nxt = r_fetch_addr + C_WORD_STEP;
                end
            end
            if (w_hit || (w_fwd && m_ready)) begin
                w_head_nxt = r_head_addr + C_WORD_STEP;
            end
            w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_hit);
        end

        w_issue = w_stream_nxt && (w_count_nxt < C_DEPTH);

        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_state_nxt  = S_FETCH;
                    w_m_addr_nxt = w_fetch_nxt;
                end
            end
            default: begin
                // Request is held stable until memory completes it.
                if (m_ready) begin
                    if (w_issue) begin
                        w_m_addr_nxt = w_fetch_nxt;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_head_addr    <= '0;
            r_fetch_addr   <= '0;
            r_count        <= '0;
            r_stream_valid <= 1'b0;
            r_discard      <= 1'b0;
            r_m_addr       <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_head_addr    <= w_head_nxt;
            r_fetch_addr   <= w_fetch_nxt;
            r_count        <= w_count_nxt;
            r_stream_valid <= w_stream_nxt;
            r_discard      <= w_discard_nxt;
            r_m_addr       <= w_m_addr_nxt;
        end
    end

    // Data storage carries no reset; occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[w_wr_idx] <= m_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iob_ibus_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_iob_ibus_prefetch
// Description : Self-checking bench for iob_ibus_prefetch. A memory model
//               with programmable latency returns a fixed function of the
//               address; a queue-based reference of the prefetch stream
//               predicts c_ready, m_valid and m_addr every cycle. Directed
//               scenarios are followed by a randomized fetch stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_ibus_prefetch;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        c_valid = 1'b0;
    logic [31:0] c_addr = '0;
    logic [31:0] c_rdata;
    logic        c_ready;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_rdata = '0;
    logic        m_ready = 1'b0;

    iob_ibus_prefetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .c_valid(c_valid),
        .c_addr (c_addr),
        .c_rdata(c_rdata),
        .c_ready(c_ready),
        .m_valid(m_valid),
        .m_addr (m_addr),
        .m_rdata(m_rdata),
        .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus state
    logic        cpu_valid = 1'b0;
    logic [31:0] cpu_addr  = '0;
    int          mem_lat   = 1;
    int          mem_age   = 0;
    int          mem_tx    = 0;
    bit          rand_lat  = 1'b0;
    logic        last_ready;

    // Reference model of the prefetch stream
    bit          md_sv, md_busy, md_bad;
    logic [31:0] md_head, md_fetch, md_req;
    logic [31:0] md_q[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        md_sv = 0; md_busy = 0; md_bad = 0;
        md_head = '0; md_fetch = '0; md_req = '0;
        md_q.delete();
    endtask

    // One clock cycle: check registered outputs, drive memory and CPU,
    // check the combinational response, then advance the reference.
    task automatic cycle();
        logic [31:0] a;
        bit seq, hit, fwd, miss, done, exp_ready;
        @(negedge clk);
        chk("m_valid", m_valid, md_busy);
        if (md_busy) chk("m_addr", m_addr, md_req);
        m_ready = m_valid && (mem_age + 1 >= mem_lat);
        m_rdata = m_ready ? memf(m_addr) : $urandom;
        c_valid = cpu_valid;
        c_addr  = cpu_addr;
        #1;
        a    = cpu_addr & 32'hFFFF_FFFC;
        seq  = md_sv && (a == md_head);
        hit  = cpu_valid && seq && (md_q.size() > 0);
        fwd  = cpu_valid && seq && (md_q.size() == 0) && md_busy && !md_bad;
        miss = cpu_valid && !seq;
        done = md_busy && m_ready;
        exp_ready = resetn && (hit || (fwd && m_ready));
        chk("c_ready", c_ready, exp_ready);
        if (exp_ready && c_ready) chk("c_rdata", c_rdata, memf(a));
        last_ready = c_ready;
        if (m_valid && m_ready) mem_tx++;
        if (m_ready) begin
            mem_age = 0;
            if (rand_lat) mem_lat = $urandom_range(1, 4);
        end else if (m_valid) begin
            mem_age++;
        end
        if (resetn) begin
            if (miss) begin
                md_q.delete();
                if (md_busy) md_bad = !m_ready;
                md_head = a; md_fetch = a; md_sv = 1;
            end else begin
                if (hit) begin
                    void'(md_q.pop_front());
                    md_head += 4;
                end
                if (done) begin
                    if (md_bad) md_bad = 0;
                    else begin
                        if (fwd) md_head += 4;
                        else md_q.push_back(md_req);
                        md_fetch += 4;
                    end
                end
            end
            if (!md_busy || done) begin
                if (md_sv && md_q.size() < DEPTH) begin
                    md_busy = 1; md_req = md_fetch;
                end else begin
                    md_busy = 0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        cpu_valid = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic fetch(input logic [31:0] a, output int lat);
        bit got;
        got = 0; lat = 0;
        cpu_valid = 1;
        cpu_addr  = a | 32'($urandom_range(0, 3));
        for (int i = 0; i < 40 && !got; i++) begin
            cycle();
            lat++;
            got = last_ready;
        end
        chk("fetch_done", got, 1'b1);
        cpu_valid = 0;
    endtask

    task automatic reset_dut();
        resetn = 0;
        cpu_valid = 0;
        model_reset();
        mem_age = 0;
        repeat (2) cycle();
        resetn = 1;
    endtask

    initial begin
        int lat;
        int tx0;
        logic [31:0] prev;
        int r;

        // Reset state, with a request pending during reset
        model_reset();
        cpu_valid = 1; cpu_addr = 32'h100;
        cycle();
        chk("rst_c_ready", c_ready, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_addr", m_addr, 32'h0);
        cpu_valid = 0;
        cycle();
        resetn = 1;
        idle(3);
        chk("no_fetch_before_req", m_valid, 1'b0);

        // First fetch is a miss: 1 cycle + 1-cycle memory, then hits
        mem_lat = 1;
        fetch(32'h100, lat); chk("lat_first_miss", lat, 2);
        fetch(32'h104, lat); chk("lat_seq_104", lat, 1);
        fetch(32'h108, lat); chk("lat_seq_108", lat, 1);

        // Branch from a primed stream; the old 0x104 word is not returned
        fetch(32'h100, lat); chk("lat_restart_100", lat, 2);
        idle(4);
        chk("primed_idle", m_valid, 1'b0);
        fetch(32'h200, lat); chk("lat_branch_200", lat, 2);
        fetch(32'h104, lat); chk("lat_back_104", lat, 2);

        // Miss while 0x108 is in flight with 4-cycle memory:
        // 1 miss cycle + 2 waits for 0x108 + 4 for the 0x300 re-issue = 7
        reset_dut();
        mem_lat = 4;
        fetch(32'h100, lat); chk("lat4_miss", lat, 5);
        fetch(32'h104, lat); chk("lat4_fwd", lat, 4);
        idle(1);
        fetch(32'h300, lat); chk("lat4_discard", lat, 7);

        // Idle CPU: exactly DEPTH further fetches, then memory stays quiet
        reset_dut();
        mem_lat = 1;
        fetch(32'h100, lat); chk("lat_idle_first", lat, 2);
        tx0 = mem_tx;
        idle(10);
        chk("idle_fill_count", mem_tx - tx0, DEPTH);
        chk("idle_quiet", m_valid, 1'b0);

        // Address wrap at the top of memory
        fetch(32'hFFFF_FFFC, lat); chk("lat_wrap_miss", lat, 2);
        idle(3);
        fetch(32'h0, lat); chk("lat_wrap_hit", lat, 1);

        // Reset while a fetch is outstanding and one word is buffered
        reset_dut();
        mem_lat = 3;
        fetch(32'h400, lat); chk("lat3_miss", lat, 4);
        for (int i = 0; i < 20 && !(md_busy && md_q.size() == 1); i++) cycle();
        @(posedge clk);
        #1;
        cpu_valid = 1; cpu_addr = 32'h404;
        c_valid = 1; c_addr = 32'h404;
        #1;
        chk("pre_rst_hit", c_ready, 1'b1);
        chk("pre_rst_m_valid", m_valid, 1'b1);
        resetn = 0;
        #1;
        chk("async_rst_m_valid", m_valid, 1'b0);
        chk("async_rst_c_ready", c_ready, 1'b0);
        model_reset();
        mem_age = 0;
        cpu_valid = 0;
        repeat (2) cycle();
        resetn = 1;
        fetch(32'h404, lat); chk("post_rst_miss", lat, 4);

        // Randomized fetch stream with random memory latency
        rand_lat = 1;
        prev = 32'h404;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            r = $urandom_range(0, 9);
            if (r < 7)      a = prev + 32'h4;
            else if (r < 9) a = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
            else            a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            fetch(a, lat);
            prev = a;
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
